// File: rtl/imm_decode_stage.sv
// Immediate-decode stage: decodes RV32I/RV64I immediates from the incoming word and
// queues {ins, pc, imm, fmt} in a two-entry skid buffer with valid/ready on both sides.
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ins,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
);
    localparam logic [2:0] FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6, FMT_Z = 3'd7;

    typedef struct packed {
        logic [31:0]     ins;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        entry_t d;
        logic   sh_f3;
        sh_f3 = (ins[13:12] == 2'b01);  // funct3 001 or 101
        d.ins = ins;
        d.pc  = pc;
        d.imm = '0;
        d.fmt = FMT_NONE;
        case (ins[6:0])
            7'b0000011, 7'b1100111: begin
                d.fmt = FMT_I;
                d.imm = XLEN'($signed(ins[31:20]));
            end
            7'b0010011: begin
                if (sh_f3) begin
                    d.fmt = FMT_SH;
                    d.imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
                end else begin
                    d.fmt = FMT_I;
                    d.imm = XLEN'($signed(ins[31:20]));
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (sh_f3) begin
                        d.fmt = FMT_SH;
                        d.imm = XLEN'(ins[24:20]);
                    end else begin
                        d.fmt = FMT_I;
                        d.imm = XLEN'($signed(ins[31:20]));
                    end
                end
            end
            7'b0100011: begin
                d.fmt = FMT_S;
                d.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                d.fmt = FMT_B;
                d.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                d.fmt = FMT_U;
                d.imm = XLEN'($signed({ins[31:12], 12'b0}));
            end
            7'b1101111: begin
                d.fmt = FMT_J;
                d.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'b1110011: begin
                if (ins[14]) begin
                    d.fmt = FMT_Z;
                    d.imm = XLEN'(ins[19:15]);
                end
            end
            default: ;
        endcase
        return d;
    endfunction

    entry_t     head, tail, nxt;
    logic [1:0] count;
    logic       push, pop;

    assign nxt       = decode(in_ins, in_pc);
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_ins = head.ins;
    assign out_pc  = head.pc;
    assign out_imm = head.imm;
    assign out_fmt = head.fmt;

    // head is always the oldest entry; tail only matters when count is 2
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= nxt;
                    else               tail <= nxt;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: head <= nxt;  // only reachable with count 1
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share stimulus; a monitor checks
// each head against an arithmetic reference decode of the queued instruction.
module tb_imm_decode_stage;
    logic        clk = 0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_ins;
    logic [63:0] in_pc;

    logic        ir32, ov32, ir64, ov64;
    logic [31:0] oins32, opc32, oimm32, oins64;
    logic [63:0] opc64, oimm64;
    logic [2:0]  ofmt32, ofmt64;

    int npass = 0, ntot = 0;
    bit mon_en = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } txn_t;
    txn_t q[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_ins(in_ins), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .out_ins(oins32), .out_pc(opc32), .out_imm(oimm32), .out_fmt(ofmt32));

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_ins(in_ins), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
        .out_ins(oins64), .out_pc(opc64), .out_imm(oimm64), .out_fmt(ofmt64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference decode from the ISA field layout using shifts and masks.
    function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        logic signed [63:0] s;
        logic [63:0] u, hi;
        int f3;
        s = {{32{ins[31]}}, ins};
        u = {32'b0, ins};
        f3 = int'(ins[14:12]);
        imm = 0;
        fmt = 0;
        case (ins[6:0])
            7'h03, 7'h67: begin fmt = 1; imm = s >>> 20; end
            7'h13: if (f3 == 1 || f3 == 5) begin
                       fmt = 6; imm = (u >> 20) & ((xlen == 64) ? 64'd63 : 64'd31);
                   end else begin fmt = 1; imm = s >>> 20; end
            7'h1B: if (xlen == 64) begin
                       if (f3 == 1 || f3 == 5) begin fmt = 6; imm = (u >> 20) & 64'd31; end
                       else begin fmt = 1; imm = s >>> 20; end
                   end
            7'h23: begin hi = s >>> 25; fmt = 2; imm = (hi << 5) | ((u >> 7) & 31); end
            7'h63: begin
                hi = s >>> 31; fmt = 3;
                imm = (hi << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
            end
            7'h37, 7'h17: begin hi = s; fmt = 4; imm = hi & ~64'hFFF; end
            7'h6F: begin
                hi = s >>> 31; fmt = 5;
                imm = (hi << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
            end
            7'h73: if (ins[14]) begin fmt = 7; imm = (u >> 15) & 31; end
            default: ;
        endcase
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
    endfunction

    always @(negedge clk) begin
        logic [63:0] e32, e64;
        logic [2:0]  f32, f64;
        if (mon_en) begin
            chk("out_valid32", ov32, q.size() > 0);
            chk("in_ready32", ir32, q.size() < 2);
            chk("out_valid64", ov64, q.size() > 0);
            chk("in_ready64", ir64, q.size() < 2);
            if (ov32 && q.size() > 0) begin
                ref_dec(q[0].ins, 32, e32, f32);
                ref_dec(q[0].ins, 64, e64, f64);
                chk("head_ins32", oins32, q[0].ins);
                chk("head_pc32", opc32, q[0].pc[31:0]);
                chk("head_imm32", oimm32, e32);
                chk("head_fmt32", ofmt32, f32);
                chk("head_ins64", oins64, q[0].ins);
                chk("head_pc64", opc64, q[0].pc);
                chk("head_imm64", oimm64, e64);
                chk("head_fmt64", ofmt64, f64);
            end
            if (rst || flush) q.delete();
            else begin
                if (ov32 && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && ir32) q.push_back('{in_ins, in_pc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        int n = 0;
        in_valid = 1; in_ins = ins; in_pc = pc;
        while (!ir32 && n < 100) begin tick(); n++; end
        if (n == 100) chk("send_timeout", 1, 0);
        tick();
        in_valid = 0;
    endtask

    // Push one word into an empty stage, check the head, then drain it.
    task automatic dir(input string nm, input logic [31:0] ins, input logic [31:0] i32,
                       input logic [2:0] f32, input logic [63:0] i64, input logic [2:0] f64);
        out_ready = 0;
        send(ins, 64'h1000);
        chk({nm, "_valid"}, ov32, 1);
        chk({nm, "_imm32"}, oimm32, i32);
        chk({nm, "_fmt32"}, ofmt32, f32);
        chk({nm, "_imm64"}, oimm64, i64);
        chk({nm, "_fmt64"}, ofmt64, f64);
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    logic [6:0] ops [12] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h0B, 7'h33};

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_ins = 0; in_pc = 0;
        tick(); tick();
        rst = 0;
        chk("rst_valid", ov32, 0);
        chk("rst_ready", ir32, 1);
        chk("rst_ins", oins32, 0);
        chk("rst_pc64", opc64, 0);
        chk("rst_imm64", oimm64, 0);
        chk("rst_fmt", ofmt32, 0);
        mon_en = 1;

        dir("beq", 32'hFE000EE3, 32'hFFFFFFFC, 3, 64'hFFFFFFFF_FFFFFFFC, 3);
        dir("srai", 32'h4030D093, 32'h3, 6, 64'h3, 6);
        dir("csr", 32'h300FD073, 32'h1F, 7, 64'h1F, 7);
        dir("unk", 32'h0000000B, 32'h0, 0, 64'h0, 0);
        dir("lui", 32'h800000B7, 32'h80000000, 4, 64'hFFFFFFFF_80000000, 4);
        dir("slliw", 32'h0030909B, 32'h0, 0, 64'h3, 6);
        dir("addiw", 32'hFFF0809B, 32'h0, 0, 64'hFFFFFFFF_FFFFFFFF, 1);

        // Backpressure: A, B fill the buffer, C waits upstream.
        out_ready = 0;
        send(32'hAAAA0013, 64'hA0);
        send(32'hBBBB0013, 64'hB0);
        in_valid = 1; in_ins = 32'hCCCC0013; in_pc = 64'hC0;
        tick();
        chk("bp_full_ready", ir32, 0);
        chk("bp_hold_A", oins32, 32'hAAAA0013);
        out_ready = 1;
        chk("bp_out_A", oins32, 32'hAAAA0013);
        tick();
        chk("bp_out_B", oins32, 32'hBBBB0013);
        tick();
        in_valid = 0;
        chk("bp_out_C", oins32, 32'hCCCC0013);
        tick();
        chk("bp_empty", ov32, 0);
        out_ready = 0;

        // Flush with a full buffer and a competing input.
        send(32'h11110013, 64'h10);
        send(32'h22220013, 64'h20);
        in_valid = 1; in_ins = 32'h33330013; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("flush2_valid", ov32, 0);
        chk("flush2_ready", ir32, 1);
        // Flush with one entry, input accepted-looking but must be dropped.
        send(32'h44440013, 64'h40);
        in_valid = 1; in_ins = 32'h55550013; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("flush1_valid", ov32, 0);
        tick();
        chk("flush1_dropped", ov32, 0);
        dir("post_flush", 32'hFE000EE3, 32'hFFFFFFFC, 3, 64'hFFFFFFFF_FFFFFFFC, 3);

        // Reset mid-stream with one entry.
        send(32'h800000B7, 64'hDEAD_BEEF_0000_1234);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_valid", ov32, 0);
        chk("mrst_ready", ir32, 1);
        chk("mrst_ins", oins64, 0);
        chk("mrst_pc", opc64, 0);
        chk("mrst_imm", oimm64, 0);
        chk("mrst_fmt", ofmt64, 0);

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_ins    = {$urandom_range(32'h01FF_FFFF), ops[$urandom_range(11)]};
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            tick();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (4) tick();
        chk("drain_empty", ov32, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode stage between fetch and the register-read/execute stage. Decodes the full RV32I/RV64I immediate set (I, S, B, U, J, shift-amount, CSR zimm), sign- or zero-extends to XLEN, and tags each entry with a format code. A two-entry skid buffer with valid/ready handshakes on both sides sustains one instruction per cycle under backpressure. A synchronous flush supports branch redirect.

## Interface
- XLEN, 32: datapath width. Legal values are 32 or 64. XLEN=64 enables OP-IMM-32 decode and 6-bit shamt.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ins  in  32  instruction word.
- in_pc  in  XLEN  instruction PC, carried through.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_ins  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH, 7 Z.

## Operation
- Decode is combinational on in_ins. The result is written into the buffer on acceptance (in_valid && in_ready).
- Opcode ins[6:0] decode, with sign bit ins[31] extended to XLEN unless noted:
  - 0000011 LOAD, 1100111 JALR: I. imm = sext(ins[31:20]).
  - 0010011 OP-IMM, funct3 001/101: SH. imm = zext(ins[24:20]) when XLEN=32, zext(ins[25:20]) when XLEN=64. Other funct3 values: I.
  - 0011011 OP-IMM-32: XLEN=64 only; XLEN=32 gives NONE. funct3 001/101 gives SH with zext(ins[24:20]); otherwise I.
  - 0100011 STORE: S. imm = sext({ins[31:25], ins[11:7]}).
  - 1100011 BRANCH: B. imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 0}).
  - 0110111 LUI, 0010111 AUIPC: U. imm = sext({ins[31:12], 12'b0}).
  - 1101111 JAL: J. imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 0}).
  - 1110011 SYSTEM, funct3[2]=1: Z. imm = zext(ins[19:15]).
  - Everything else: NONE, imm = 0.
- Buffer: 2 entries, FIFO order. Each entry holds {ins, pc, imm, fmt}. count ranges 0..2.
- in_ready = (count < 2). It depends only on registered count, never combinationally on out_ready.
- out_valid = (count > 0). out_* present the head entry directly from registers.
- Count update per cycle:
  - push only: +1.
  - pop only (out_valid && out_ready): -1.
  - push and pop together: unchanged; the new entry goes behind the head.
- Priority: rst > flush > normal operation.
  - flush sets count to 0 and drops any same-cycle input, even when in_ready=1.
  - flush has no effect on out_* data registers other than out_valid.
- Reset: count=0, out_valid=0, in_ready=1 (from the following cycle). out_ins=0, out_pc=0, out_imm=0, out_fmt=0.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N; it can be consumed at edge N+1 at the earliest.
- Throughput: 1 entry/cycle when out_ready is held high.
- With count=2: in_ready=0. A pop at edge N makes in_ready=1 after edge N.
- After flush asserted at edge N: out_valid=0 and in_ready=1 after N.
- Reset mid-stream: identical to flush, and additionally clears the data registers.
- Data held stable while out_valid && !out_ready.

## Test plan
- B-type: in_ins=0xFE000EE3 (beq x0,x0,-4), XLEN=32 -> out_imm=0xFFFFFFFC, out_fmt=3, out_valid one cycle after acceptance.
- Shift: in_ins=0x4030D093 (srai x1,x1,3) -> out_imm=0x00000003, out_fmt=6 (not 0x403). CSR: in_ins=0x300FD073 -> out_imm=0x1F, out_fmt=7. Unknown in_ins=0x0000000B -> out_imm=0, out_fmt=0.
- XLEN=64: in_ins=0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4.
- Backpressure: out_ready=0, three back-to-back pushes A,B,C.
  - A and B are accepted; in_ready=0 afterwards; C is held upstream.
  - Raise out_ready: outputs A, B, C in order on consecutive cycles, none lost or duplicated.
- Flush: count=2, in_valid=1, flush=1 on the same edge -> next cycle out_valid=0, in_ready=1, input dropped. The following push emerges with correct imm.
- Reset mid-stream with count=1: next cycle all outputs are 0 and in_ready=1.
